// File: rtl/bytecode_fetch.sv
// bytecode_fetch: bytecode instruction fetch unit with synchronous program memory,
// decoder argc lookup and valid/ready delivery to execute, applying branch redirects.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   o_mem_addr/o_mem_rd/i_mem_data   program memory port (data one cycle after rd)
//   o_opcode/i_argc   opcode to decoder, argument count back (2'b11 counts as 2)
//   o_arg1/o_arg2/o_op_pc/o_op_valid/i_op_ready   instruction handshake to execute
//   i_br_taken/i_br_offset   redirect applied on accept, target = op_pc + sext(offset)
module bytecode_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_data,
    output logic [7:0]        o_opcode,
    input  logic [1:0]        i_argc,
    output logic [7:0]        o_arg1,
    output logic [7:0]        o_arg2,
    output logic [ADDR_W-1:0] o_op_pc,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    input  logic              i_br_taken,
    input  logic [15:0]       i_br_offset
);
    localparam int XW = ADDR_W > 16 ? ADDR_W : 16;
    typedef enum logic [2:0] {S_OP, S_OPW, S_DEC, S_A1, S_A1W, S_A2, S_A2W, S_HOLD} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pc, r_mem_addr, r_op_pc, w_target;
    logic [7:0]        r_opcode, r_arg1, r_arg2;
    logic              r_two, w_rd;
    logic [XW-1:0]     w_off;
    assign w_off      = XW'($signed(i_br_offset));
    assign w_target   = r_op_pc + w_off[ADDR_W-1:0];
    // the read address is live pc while reading, otherwise the last address read
    assign o_mem_addr = w_rd ? r_pc : r_mem_addr;
    // reset parks the FSM in S_OP, so the strobe must be suppressed while rst is high
    assign o_mem_rd   = w_rd & ~i_rst;
    assign o_op_valid = r_state == S_HOLD;
    assign o_opcode   = r_opcode;
    assign o_arg1     = r_arg1;
    assign o_arg2     = r_arg2;
    assign o_op_pc    = r_op_pc;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_OP;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        case (r_state)
            S_OP:    begin w_rd = 1'b1; w_next = S_OPW; end
            S_OPW:   w_next = S_DEC;
            S_DEC:   w_next = i_argc == 2'd0 ? S_HOLD : S_A1;
            S_A1:    begin w_rd = 1'b1; w_next = S_A1W; end
            S_A1W:   w_next = r_two ? S_A2 : S_HOLD;
            S_A2:    begin w_rd = 1'b1; w_next = S_A2W; end
            S_A2W:   w_next = S_HOLD;
            S_HOLD:  w_next = i_op_ready ? S_OP : S_HOLD;
            default: w_next = S_OP;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_op_pc    <= '0;
            r_opcode   <= 8'h00;
            r_arg1     <= 8'h00;
            r_arg2     <= 8'h00;
            r_two      <= 1'b0;
        end else begin
            if (w_rd) r_mem_addr <= r_pc;
            case (r_state)
                S_OP:  r_op_pc <= r_pc;
                S_OPW: begin
                    r_opcode <= i_mem_data;
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_arg1   <= 8'h00;
                    r_arg2   <= 8'h00;
                end
                // argc of 2 or 3 both mean two argument bytes, so bit 1 is all we keep
                S_DEC: r_two <= i_argc[1];
                S_A1W: begin
                    r_arg1 <= i_mem_data;
                    r_pc   <= r_pc + ADDR_W'(1);
                end
                S_A2W: begin
                    r_arg2 <= i_mem_data;
                    r_pc   <= r_pc + ADDR_W'(1);
                end
                S_HOLD: if (i_op_ready && i_br_taken) r_pc <= w_target;
                default: ;
            endcase
        end
    end
endmodule
